// File: rtl/filter_bcd_pkg.sv
// Shared types and constants for the BCD digit filter.
// Optional hold-last-legal behaviour is selected with FILTER_BCD_HOLD_EN.
package filter_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_SAFE = 4'd0;

endpackage

// File: rtl/filter_bcd_check.sv
// Combinational legality check for a single 4-bit code; illegal codes map to
// the safe digit here, the hold substitution is applied in the top level.
module bcd_check
    import filter_bcd_pkg::*;
(
    input  logic [3:0] code,
    output logic       legal,
    output logic [3:0] digit
);

    always_comb begin
        legal = (code <= BCD_MAX);
        digit = legal ? code : BCD_SAFE;
    end

endmodule

// File: rtl/filter_bcd.sv
// Registered BCD digit filter with a saturating rejected-code counter.
// Define FILTER_BCD_HOLD_EN to replace illegal codes with the last legal digit.
module filter_bcd
    import filter_bcd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in,
    input  logic             in_valid,
    input  logic             clr_count,
    output logic [3:0]       out,
    output logic             out_valid,
    output logic             error,
    output logic [CNT_W-1:0] err_count
);

    logic       legal;
    bcd_digit_t checkedDigit;
    bcd_digit_t nextDigit;

    bcd_check u_check (
        .code  (in),
        .legal (legal),
        .digit (checkedDigit)
    );

`ifdef FILTER_BCD_HOLD_EN
    bcd_digit_t holdDigit;

    // Remembers the most recent legal digit so illegal codes can repeat it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            holdDigit <= BCD_SAFE;
        end else if (in_valid && legal) begin
            holdDigit <= in;
        end
    end

    assign nextDigit = legal ? checkedDigit : holdDigit;
`else
    assign nextDigit = checkedDigit;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= BCD_SAFE;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            error     <= in_valid && !legal;
            if (in_valid) begin
                out <= nextDigit;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (in_valid && !legal && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_filter_bcd.sv
// Self-checking bench for filter_bcd: a default-width instance and a 3-bit
// counter instance share stimulus and are compared against a reference model.
module tb_filter_bcd;

    logic       clk;
    logic       rst_n;
    logic [3:0] code;
    logic       codeValid;
    logic       clrCount;

    logic [3:0] outA;
    logic       validA;
    logic       errorA;
    logic [7:0] countA;
    logic [3:0] outB;
    logic       validB;
    logic       errorB;
    logic [2:0] countB;

    int passCount  = 0;
    int checkCount = 0;

    int expOut;
    int expValid;
    int expError;
    int expCountA;
    int expCountB;
    int lastLegal;

    filter_bcd #(.CNT_W(8)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (code),
        .in_valid  (codeValid),
        .clr_count (clrCount),
        .out       (outA),
        .out_valid (validA),
        .error     (errorA),
        .err_count (countA)
    );

    filter_bcd #(.CNT_W(3)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (code),
        .in_valid  (codeValid),
        .clr_count (clrCount),
        .out       (outB),
        .out_valid (validB),
        .error     (errorB),
        .err_count (countB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, step the reference model at the edge, settle 1 time unit.
    task automatic driveCycle(input int c, input bit v, input bit clr, input bit rn);
        code      = c[3:0];
        codeValid = v;
        clrCount  = clr;
        rst_n     = rn;
        @(posedge clk);
        if (!rn) begin
            expOut = 0; expValid = 0; expError = 0;
            expCountA = 0; expCountB = 0; lastLegal = 0;
        end else begin
            expValid = v;
            expError = v && (c > 9);
            if (v) begin
                if (c <= 9) begin
                    expOut    = c;
                    lastLegal = c;
                end else begin
`ifdef FILTER_BCD_HOLD_EN
                    expOut = lastLegal;
`else
                    expOut = 0;
`endif
                end
            end
            if (clr) begin
                expCountA = 0;
                expCountB = 0;
            end else if (v && c > 9) begin
                expCountA = (expCountA >= 255) ? 255 : expCountA + 1;
                expCountB = (expCountB >= 7) ? 7 : expCountB + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        driveCycle(7, 1, 0, 1);
        driveCycle(12, 1, 0, 0);
        checkCount++;
        if (outA !== 4'd0) $display("[TB] FAIL reset_out got %0d want 0", outA);
        else passCount++;
        checkCount++;
        if (validA !== 1'b0) $display("[TB] FAIL reset_valid got %0b want 0", validA);
        else passCount++;
        checkCount++;
        if (errorA !== 1'b0) $display("[TB] FAIL reset_error got %0b want 0", errorA);
        else passCount++;
        checkCount++;
        if (countA !== 8'd0 || countB !== 3'd0)
            $display("[TB] FAIL reset_count got %0d/%0d want 0/0", countA, countB);
        else passCount++;
    endtask

    task automatic test_sweep();
        driveCycle(0, 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            driveCycle(c, 1, 0, 1);
            checkCount++;
            if (outA !== expOut[3:0] || validA !== 1'b1 || errorA !== (c > 9))
                $display("[TB] FAIL sweep_%0d got out=%0d v=%0b e=%0b want out=%0d v=1 e=%0b",
                         c, outA, validA, errorA, expOut, (c > 9));
            else passCount++;
        end
        checkCount++;
        if (countA !== 8'd6) $display("[TB] FAIL sweep_count got %0d want 6", countA);
        else passCount++;
    endtask

    task automatic test_gaps();
        driveCycle(0, 0, 0, 0);
        driveCycle(5, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            driveCycle($urandom_range(15, 0), 0, 0, 1);
            checkCount++;
            if (outA !== 4'd5 || validA !== 1'b0 || errorA !== 1'b0)
                $display("[TB] FAIL gap_%0d got out=%0d v=%0b e=%0b want out=5 v=0 e=0",
                         i, outA, validA, errorA);
            else passCount++;
        end
        driveCycle(11, 1, 0, 1);
        checkCount++;
        if (errorA !== 1'b1 || validA !== 1'b1 || countA !== 8'd1)
            $display("[TB] FAIL gap_error got e=%0b v=%0b cnt=%0d want e=1 v=1 cnt=1",
                     errorA, validA, countA);
        else passCount++;
    endtask

    task automatic test_saturation();
        driveCycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) driveCycle($urandom_range(15, 10), 1, 0, 1);
        checkCount++;
        if (countB !== 3'd7) $display("[TB] FAIL sat_narrow got %0d want 7", countB);
        else passCount++;
        checkCount++;
        if (countA !== 8'd10) $display("[TB] FAIL sat_wide got %0d want 10", countA);
        else passCount++;
    endtask

    task automatic test_clear();
        driveCycle(14, 1, 1, 1);
        checkCount++;
        if (countA !== 8'd0 || countB !== 3'd0 || errorA !== 1'b1 || validA !== 1'b1)
            $display("[TB] FAIL clear_priority got cnt=%0d/%0d e=%0b v=%0b want 0/0 e=1 v=1",
                     countA, countB, errorA, validA);
        else passCount++;
    endtask

    task automatic test_hold();
        int seq [4] = '{3, 15, 13, 7};
        int errs[4] = '{0, 1, 1, 0};
`ifdef FILTER_BCD_HOLD_EN
        int outs[4] = '{3, 3, 3, 7};
`else
        int outs[4] = '{3, 0, 0, 7};
`endif
        driveCycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            driveCycle(seq[i], 1, 0, 1);
            checkCount++;
            if (outA !== outs[i][3:0] || errorA !== errs[i][0])
                $display("[TB] FAIL hold_%0d got out=%0d e=%0b want out=%0d e=%0d",
                         i, outA, errorA, outs[i], errs[i]);
            else passCount++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            driveCycle($urandom_range(15, 0), ($urandom_range(3, 0) != 0),
                       ($urandom_range(15, 0) == 0), ($urandom_range(31, 0) != 0));
            checkCount++;
            if (outA !== expOut[3:0] || validA !== expValid[0] || errorA !== expError[0] ||
                countA !== expCountA[7:0] || countB !== expCountB[2:0] ||
                outB !== outA || validB !== validA || errorB !== errorA)
                $display("[TB] FAIL random_%0d got out=%0d v=%0b e=%0b cnt=%0d/%0d want out=%0d v=%0d e=%0d cnt=%0d/%0d",
                         i, outA, validA, errorA, countA, countB,
                         expOut, expValid, expError, expCountA, expCountB);
            else passCount++;
        end
    endtask

    initial begin
        code = 4'd0; codeValid = 1'b0; clrCount = 1'b0; rst_n = 1'b0;
        expOut = 0; expValid = 0; expError = 0;
        expCountA = 0; expCountB = 0; lastLegal = 0;
        driveCycle(0, 0, 0, 0);
        test_reset();
        test_sweep();
        test_gaps();
        test_saturation();
        test_clear();
        test_hold();
        test_random();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
